// File: rtl/lisa_qspi_arbiter.sv
// Round-robin arbiter sharing one lisa_qqspi controller among NUM_REQ requesters.
// Optional macro LISA_QSPI_ARB_LOCK_EN adds req_lock to keep multi-transaction sequences atomic.
module lisa_qspi_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int CHIP_SELECTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*24-1:0]           req_addr,
  input  logic [NUM_REQ*16-1:0]           req_wdata,
  input  logic [NUM_REQ*2-1:0]            req_wstrb,
  input  logic [NUM_REQ*4-1:0]            req_len,
  input  logic [NUM_REQ*CHIP_SELECTS-1:0] req_cs,
  input  logic [NUM_REQ-1:0]              req_wack,
`ifdef LISA_QSPI_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]              req_lock,
`endif
  output logic [NUM_REQ-1:0]              req_gnt,
  output logic [NUM_REQ-1:0]              req_word,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [15:0]                     req_rdata,
  output logic [23:0]                     mem_addr,
  output logic [15:0]                     mem_wdata,
  output logic [1:0]                      mem_wstrb,
  output logic [3:0]                      mem_xfer_len,
  output logic [CHIP_SELECTS-1:0]         mem_ce_ctrl,
  output logic                            mem_valid,
  output logic                            mem_ready_ack,
  input  logic [15:0]                     mem_rdata,
  input  logic                            mem_ready,
  input  logic                            mem_xfer_done
);
  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [IDXW-1:0]     gnt_idx, gnt_idx_nxt;
  logic [IDXW-1:0]     rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt, word_nxt, done_nxt;
  logic [15:0]         rdata_nxt;
  logic                valid_nxt;
  logic                ready_q;
  logic                lock_hold, lock_nxt;
  logic                lock_cur;
  logic                gnt_act;
  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic [IDXW-1:0]     cand;

  logic [NUM_REQ-1:0][23:0]             addr_a;
  logic [NUM_REQ-1:0][15:0]             wdata_a;
  logic [NUM_REQ-1:0][1:0]              wstrb_a;
  logic [NUM_REQ-1:0][3:0]              len_a;
  logic [NUM_REQ-1:0][CHIP_SELECTS-1:0] cs_a;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;
  assign wstrb_a = req_wstrb;
  assign len_a   = req_len;
  assign cs_a    = req_cs;

  // Request fields are steered only while a grant is held, so the bus idles at 0.
  assign gnt_act       = |req_gnt;
  assign mem_addr      = gnt_act ? addr_a[gnt_idx]  : '0;
  assign mem_wdata     = gnt_act ? wdata_a[gnt_idx] : '0;
  assign mem_wstrb     = gnt_act ? wstrb_a[gnt_idx] : '0;
  assign mem_xfer_len  = gnt_act ? len_a[gnt_idx]   : '0;
  assign mem_ce_ctrl   = gnt_act ? cs_a[gnt_idx]    : '0;
  assign mem_ready_ack = gnt_act & req_wack[gnt_idx];

`ifdef LISA_QSPI_ARB_LOCK_EN
  assign lock_cur = req_lock[gnt_idx];
`else
  assign lock_cur = 1'b0;
`endif

  // Round-robin scan starting just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    rr_nxt      = rr_ptr;
    gnt_nxt     = req_gnt;
    word_nxt    = '0;
    done_nxt    = '0;
    rdata_nxt   = req_rdata;
    valid_nxt   = mem_valid;
    lock_nxt    = lock_hold;
    case (state)
      IDLE: begin
        if (pick_found && !mem_ready) begin
          gnt_idx_nxt       = pick_idx;
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          state_nxt         = GRANT;
        end
      end
      GRANT: begin
        valid_nxt = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (mem_ready && !ready_q) begin
          word_nxt[gnt_idx] = 1'b1;
          rdata_nxt         = mem_rdata;
        end
        if (mem_xfer_done) begin
          valid_nxt         = 1'b0;
          done_nxt[gnt_idx] = 1'b1;
          lock_nxt          = lock_cur;
          if (!lock_cur) rr_nxt = gnt_idx;
          state_nxt         = RELEASE;
        end
      end
      RELEASE: begin
        valid_nxt = 1'b0;
        // Controller must drop ready before it may see another valid.
        if (!mem_ready) begin
          if (lock_hold && req_valid[gnt_idx]) begin
            state_nxt = GRANT;
          end else begin
            gnt_nxt   = '0;
            rr_nxt    = gnt_idx;
            lock_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      rr_ptr    <= IDXW'(NUM_REQ - 1);
      req_gnt   <= '0;
      req_word  <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      mem_valid <= 1'b0;
      ready_q   <= 1'b0;
      lock_hold <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= gnt_idx_nxt;
      rr_ptr    <= rr_nxt;
      req_gnt   <= gnt_nxt;
      req_word  <= word_nxt;
      req_done  <= done_nxt;
      req_rdata <= rdata_nxt;
      mem_valid <= valid_nxt;
      ready_q   <= mem_ready;
      lock_hold <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_lisa_qspi_arbiter.sv
// Bench for lisa_qspi_arbiter: directed scenarios plus randomized request mixes,
// with the bench acting as the QSPI controller and a round-robin reference model.
module tb_lisa_qspi_arbiter;
  localparam int N  = 3;
  localparam int CS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid, req_wack, req_gnt, req_word, req_done;
  logic [N*24-1:0]  req_addr;
  logic [N*16-1:0]  req_wdata;
  logic [N*2-1:0]   req_wstrb;
  logic [N*4-1:0]   req_len;
  logic [N*CS-1:0]  req_cs;
  logic [15:0]      req_rdata, mem_wdata, mem_rdata;
  logic [23:0]      mem_addr;
  logic [1:0]       mem_wstrb;
  logic [3:0]       mem_xfer_len;
  logic [CS-1:0]    mem_ce_ctrl;
  logic             mem_valid, mem_ready_ack, mem_ready, mem_xfer_done;
`ifdef LISA_QSPI_ARB_LOCK_EN
  logic [N-1:0]     req_lock;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [23:0]   addr_m  [N];
  logic [15:0]   wdata_m [N];
  logic [1:0]    wstrb_m [N];
  logic [3:0]    len_m   [N];
  logic [CS-1:0] cs_m    [N];
  int            rr_m;
  int            rd_fix;

  lisa_qspi_arbiter #(.NUM_REQ(N), .CHIP_SELECTS(CS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_len(req_len), .req_cs(req_cs), .req_wack(req_wack),
`ifdef LISA_QSPI_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_gnt(req_gnt), .req_word(req_word), .req_done(req_done), .req_rdata(req_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_xfer_len(mem_xfer_len), .mem_ce_ctrl(mem_ce_ctrl), .mem_valid(mem_valid),
    .mem_ready_ack(mem_ready_ack), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_xfer_done(mem_xfer_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference round-robin: first pending requester after the last one served.
  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 1; k <= N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic rand_fields(input int r);
    addr_m[r]  = 24'($urandom);
    wdata_m[r] = 16'($urandom);
    wstrb_m[r] = 2'($urandom);
    len_m[r]   = 4'($urandom_range(0, 3));
    cs_m[r]    = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
  endtask

  task automatic drive_fields();
    for (int r = 0; r < N; r++) begin
      req_addr[24*r +: 24] = addr_m[r];
      req_wdata[16*r +: 16] = wdata_m[r];
      req_wstrb[2*r +: 2]   = wstrb_m[r];
      req_len[4*r +: 4]     = len_m[r];
      req_cs[CS*r +: CS]    = cs_m[r];
    end
  endtask

  task automatic grant_lat(input int idx);
    int n;
    n = 0;
    while (req_gnt === '0 && n < 20) begin tick(); n++; end
    chk("grant_onehot", req_gnt, oh(idx));
    chk("valid_at_grant", mem_valid, 1'b0);
    tick();
    chk("valid_after_grant", mem_valid, 1'b1);
  endtask

  // Plays the controller for one granted transaction of requester idx.
  task automatic run_txn(input int idx, input int hold_after);
    int n;
    logic [15:0] d;
    n = 0;
    while (mem_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("mem_valid_up", mem_valid, 1'b1);
    chk("gnt", req_gnt, oh(idx));
    chk("mem_addr", mem_addr, addr_m[idx]);
    chk("mem_wdata", mem_wdata, wdata_m[idx]);
    chk("mem_wstrb", mem_wstrb, wstrb_m[idx]);
    chk("mem_len", mem_xfer_len, len_m[idx]);
    chk("mem_ce", mem_ce_ctrl, cs_m[idx]);
    for (int w = 0; w <= int'(len_m[idx]); w++) begin
      repeat ($urandom_range(0, 2)) tick();
      d = (rd_fix >= 0) ? 16'(rd_fix) : 16'($urandom);
      mem_rdata = d;
      mem_ready = 1'b1;
      req_wack  = 3'($urandom);
      #1;
      chk("ready_ack", mem_ready_ack, req_wack[idx]);
      tick();
      chk("word", req_word, oh(idx));
      chk("rdata", req_rdata, d);
      if (!(w == int'(len_m[idx]) && hold_after > 0)) begin
        repeat ($urandom_range(0, 1)) begin tick(); chk("word_single", req_word, '0); end
        mem_ready = 1'b0;
        tick();
        chk("word_gap", req_word, '0);
      end
    end
    req_wack = '0;
    mem_xfer_done = 1'b1;
    tick();
    mem_xfer_done = 1'b0;
    chk("done", req_done, oh(idx));
    chk("valid_drop", mem_valid, 1'b0);
    chk("word_at_done", req_word, '0);
    for (int h = 0; h < hold_after; h++) begin
      tick();
      chk("hold_valid", mem_valid, 1'b0);
      chk("hold_gnt", req_gnt, oh(idx));
      chk("hold_done", req_done, '0);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int order [4] = '{0, 1, 2, 0};
    logic [N-1:0] pend;
    int exp;
    req_valid = '0; req_wack = '0; mem_rdata = '0; mem_ready = 1'b0; mem_xfer_done = 1'b0;
`ifdef LISA_QSPI_ARB_LOCK_EN
    req_lock = '0;
`endif
    rd_fix = -1;
    for (int r = 0; r < N; r++) rand_fields(r);
    drive_fields();

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", req_gnt, '0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_word", req_word, '0);
    chk("rst_done", req_done, '0);
    chk("rst_rdata", req_rdata, '0);
    chk("rst_ack", mem_ready_ack, 1'b0);
    chk("rst_addr", mem_addr, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    rr_m = N - 1;
    tick();

    // xfer_done while idle has no effect
    mem_xfer_done = 1'b1;
    tick();
    mem_xfer_done = 1'b0;
    tick();
    chk("idle_done", req_done, '0);
    chk("idle_gnt", req_gnt, '0);
    chk("idle_valid", mem_valid, 1'b0);

    // Single read from requester 0
    addr_m[0] = 24'h000100; wstrb_m[0] = 2'b00; len_m[0] = 4'd0; cs_m[0] = 2'b01;
    drive_fields();
    rd_fix = 16'hBEEF;
    req_valid = 3'b001;
    grant_lat(0);
    run_txn(0, 0);
    rd_fix = -1;
    req_valid = '0;

    // All three pending from a fresh reset: 0,1,2,0
    rst = 1'b1;
    #2 rst = 1'b0;
    rr_m = N - 1;
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) run_txn(order[i], 0);
    rr_m = 0;
    req_valid = '0;

    // Write burst from requester 1
    wstrb_m[1] = 2'b11; len_m[1] = 4'd3;
    drive_fields();
    req_valid = 3'b010;
    run_txn(1, 0);
    rr_m = 1;
    req_valid = '0;

    // Ready held high after xfer_done while requester 0 waits
    req_valid = 3'b101;
    exp = pick(req_valid, rr_m);
    run_txn(exp, 5);
    rr_m = exp;
    req_valid[exp] = 1'b0;
    exp = pick(req_valid, rr_m);
    run_txn(exp, 0);
    rr_m = exp;
    req_valid = '0;

    // Randomized request mixes
    pend = '0;
    for (int t = 0; t < 20; t++) begin
      if (pend == '0) pend = 3'($urandom_range(1, 7));
      req_valid = pend;
      exp = pick(pend, rr_m);
      run_txn(exp, ($urandom_range(0, 3) == 0) ? 2 : 0);
      rr_m = exp;
      pend[exp] = 1'b0;
      rand_fields(exp);
      drive_fields();
      pend = pend | 3'($urandom_range(0, 7));
      req_valid = pend;
    end
    req_valid = '0;
    repeat (3) tick();

    // Async reset in the middle of a transfer
    req_valid = 3'b111;
    exp = pick(req_valid, rr_m);
    begin
      int n;
      n = 0;
      while (mem_valid !== 1'b1 && n < 40) begin tick(); n++; end
    end
    chk("prerst_gnt", req_gnt, oh(exp));
    mem_rdata = 16'h1234;
    mem_ready = 1'b1;
    tick();
    chk("prerst_word", req_word, oh(exp));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", mem_valid, 1'b0);
    chk("midrst_gnt", req_gnt, '0);
    chk("midrst_word", req_word, '0);
    chk("midrst_done", req_done, '0);
    mem_ready = 1'b0;
    #3 rst = 1'b0;
    rr_m = N - 1;
    grant_lat(0);
    run_txn(0, 0);
    rr_m = 0;
    req_valid = '0;

`ifdef LISA_QSPI_ARB_LOCK_EN
    // Locked requester 2 keeps the controller for a second transaction
    req_lock = 3'b100;
    req_valid = 3'b100;
    run_txn(2, 0);
    req_valid = 3'b101;
    req_lock = 3'b000;
    tick();
    chk("lock_regrant", req_gnt, 3'b100);
    run_txn(2, 0);
    req_valid = 3'b001;
    run_txn(0, 0);
    req_valid = '0;
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lisa_qspi_arbiter.md
Name: lisa_qspi_arbiter

Overview:
- Shares one lisa_qqspi SPI/QSPI memory controller among NUM_REQ requesters, e.g. instruction fetch, data load/store and debug.
- Arbitrates round-robin and routes the winner's request fields and chip-select to the controller.
- Sequences the controller's valid/ready/xfer_done protocol and returns per-word strobes and completion to the granted requester only.

Parameters:
NUM_REQ, 3, number of requesters (2..4).
CHIP_SELECTS, 2, width of the controller ce_ctrl bus.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  request pending, held until req_done
req_addr  in  NUM_REQ*24  byte address per requester (slice r at [24r+23:24r])
req_wdata  in  NUM_REQ*16  write data per requester
req_wstrb  in  NUM_REQ*2  byte strobes per requester; 0 = read
req_len  in  NUM_REQ*4  extra words beyond the first (controller xfer_len)
req_cs  in  NUM_REQ*CHIP_SELECTS  one-hot chip select per requester
req_wack  in  NUM_REQ  next wdata presented (write bursts)
req_gnt  out  NUM_REQ  one-hot grant
req_word  out  NUM_REQ  1-cycle strobe: rdata word valid / wdata consumed
req_done  out  NUM_REQ  1-cycle strobe: transaction complete
req_rdata  out  16  shared read data; valid when req_word is high
mem_addr  out  24  to controller addr
mem_wdata  out  16  to controller wdata
mem_wstrb  out  2  to controller wstrb
mem_xfer_len  out  4  to controller xfer_len
mem_ce_ctrl  out  CHIP_SELECTS  to controller ce_ctrl
mem_valid  out  1  to controller valid
mem_ready_ack  out  1  to controller ready_ack
mem_rdata  in  16  from controller rdata
mem_ready  in  1  from controller ready
mem_xfer_done  in  1  from controller xfer_done

Behaviour:
- Reset (async assert, sync release) clears all outputs to 0, sets state IDLE and sets rr_ptr to NUM_REQ-1.
- FSM states: IDLE, GRANT, BUSY, RELEASE.
- IDLE:
  - Waits for any req_valid and mem_ready==0.
  - Picks the first asserted requester scanning upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Registers its index in gnt_idx and sets req_gnt one-hot; next state GRANT.
- GRANT:
  - mem_* fields are driven from slice gnt_idx and are stable for the whole grant.
  - mem_valid=1; next state BUSY.
  - Grant-to-mem_valid latency is 1 cycle after the IDLE decision.
- BUSY:
  - req_word[gnt_idx] pulses on each mem_ready 0->1 edge.
  - req_rdata is captured from mem_rdata on that edge.
  - mem_ready_ack = req_wack[gnt_idx] (combinational pass-through), gated by grant.
  - On mem_xfer_done=1: mem_valid drops next cycle, req_done[gnt_idx] pulses, rr_ptr<=gnt_idx; next state RELEASE.
- RELEASE:
  - mem_valid=0; waits for mem_ready==0, which the controller clears on idle with !valid.
  - Then req_gnt<=0; next state IDLE.
  - This guarantees the controller never sees a new valid while ready is still high.
- Non-granted requesters never receive req_word/req_done; their req_gnt is 0.
- A requester dropping req_valid mid-grant is ignored. The transaction runs to xfer_done, because the controller cannot abort.
- Simultaneous requests resolve by round-robin. A sole requester may be granted back-to-back, with at least 2 idle cycles (RELEASE, IDLE) between transactions.
- gnt_idx >= NUM_REQ is unreachable; on any unused state the FSM returns to IDLE with mem_valid=0.
- mem_xfer_done in IDLE or RELEASE is ignored.

Optional Feature:
LISA_QSPI_ARB_LOCK_EN:
- When defined, the block adds input req_lock[NUM_REQ].
- If req_lock[gnt_idx]=1 at xfer_done, RELEASE returns to GRANT for the same requester instead of IDLE, once mem_ready==0 and req_valid[gnt_idx]=1. rr_ptr is not advanced.
- This keeps flash command sequences (custom cmd followed by data) atomic.
- Without the macro, no lock input exists and every transaction re-arbitrates.

Test Plan:
- Single read, req 0 (addr 24'h000100, wstrb 0, len 0, cs 2'b01) -> mem_valid rises 1 cycle after grant; one req_word[0] with req_rdata=mem_rdata=16'hBEEF; one req_done[0]; mem_valid=0 within 1 cycle of xfer_done.
- Requesters 0,1,2 all valid continuously, rr_ptr=2 after reset -> grant order 0,1,2,0; no requester granted twice before others.
- Write burst, req 1 (wstrb 2'b11, len 3) -> 4 req_word[1] strobes; mem_ready_ack follows req_wack[1] only; req_word[0]/[2] stay 0.
- Controller keeps mem_ready=1 for 5 cycles after xfer_done -> arbiter stays in RELEASE with mem_valid=0; no new grant until mem_ready=0.
- rst asserted mid-BUSY (async, between clocks) -> mem_valid, req_gnt, req_word, req_done go 0 immediately; after release, first grant goes to requester 0.
- With LISA_QSPI_ARB_LOCK_EN, req 2 locked and req 0 pending -> two consecutive req 2 transactions, then req 0 granted once lock is dropped.
